// File: rtl/pc_icache_pkg.sv
// Shared constants and types for the fetch-stage PC / instruction cache.
//   - address/data widths and cache geometry
//   - BOOT_PC, the PC value after reset
//   - refill_state_t, the refill FSM encoding (IDLE/REQ/ACK)
package pc_icache_pkg;

  localparam int VIRT_ADDR_WIDTH   = 32;
  localparam int INST_WIDTH        = 32;
  localparam int ICACHE_LINE_WIDTH = 128;
  localparam int ICACHE_LINES      = 4;
  localparam int MEM_ADDRESS_LEN   = 32;

  localparam logic [VIRT_ADDR_WIDTH-1:0] BOOT_PC = 32'h0000_1000;

  // Address split: [tag | index | word | byte]
  localparam int WORDS_PER_LINE = ICACHE_LINE_WIDTH / INST_WIDTH;
  localparam int WORD_BITS      = $clog2(WORDS_PER_LINE);
  localparam int OFFSET_BITS    = WORD_BITS + 2;
  localparam int INDEX_BITS     = $clog2(ICACHE_LINES);
  localparam int TAG_LSB        = OFFSET_BITS + INDEX_BITS;
  localparam int TAG_BITS       = VIRT_ADDR_WIDTH - TAG_LSB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } refill_state_t;

endpackage

// File: rtl/pc_icache_array.sv
// Direct-mapped instruction cache: tag/valid/data arrays plus the refill FSM.
//   pc                       in   current fetch PC
//   wrt_en                   in   pipeline enable; gates new refill requests
//   instr_from_mem           in   refill line
//   mem_data_rdy             in   refill line valid (honoured only in REQ)
//   data_filled_ack          in   end of refill transaction (honoured only in ACK)
//   instruction              out  selected word on hit, 0 on miss
//   hit                      out  valid line with matching tag
//   request_inst_memory      out  refill request, high while in REQ
//   request_inst_memory_addr out  line-aligned refill address
module pc_icache_array
  import pc_icache_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [VIRT_ADDR_WIDTH-1:0]   pc,
  input  logic                         wrt_en,
  input  logic [ICACHE_LINE_WIDTH-1:0] instr_from_mem,
  input  logic                         mem_data_rdy,
  input  logic                         data_filled_ack,
  output logic [INST_WIDTH-1:0]        instruction,
  output logic                         hit,
  output logic                         request_inst_memory,
  output logic [MEM_ADDRESS_LEN-1:0]   request_inst_memory_addr
);

  logic [TAG_BITS-1:0]          tag_q  [ICACHE_LINES];
  logic [ICACHE_LINE_WIDTH-1:0] data_q [ICACHE_LINES];
  logic [ICACHE_LINES-1:0]      valid_q;

  refill_state_t state_q, state_d;
  logic          fill;
  logic          start_req;

  logic [WORD_BITS-1:0]         word;
  logic [INDEX_BITS-1:0]        index;
  logic [TAG_BITS-1:0]          tag;
  logic [INDEX_BITS-1:0]        fill_index;
  logic [TAG_BITS-1:0]          fill_tag;
  logic [ICACHE_LINE_WIDTH-1:0] line;

  assign word  = pc[OFFSET_BITS-1:2];
  assign index = pc[TAG_LSB-1:OFFSET_BITS];
  assign tag   = pc[VIRT_ADDR_WIDTH-1:TAG_LSB];

  // The fill target comes from the latched request address, not the live PC,
  // so a branch during the refill cannot redirect the write.
  assign fill_index = request_inst_memory_addr[TAG_LSB-1:OFFSET_BITS];
  assign fill_tag   = request_inst_memory_addr[VIRT_ADDR_WIDTH-1:TAG_LSB];

  // Byte offset within the word is irrelevant for aligned fetch.
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, pc[1:0]};

  assign hit         = valid_q[index] && (tag_q[index] == tag);
  assign line        = data_q[index];
  assign instruction = hit ? line[int'(word)*INST_WIDTH +: INST_WIDTH] : '0;

  assign start_req           = (state_q == IDLE) && !hit && wrt_en;
  assign request_inst_memory = (state_q == REQ);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    fill    = 1'b0;
    unique case (state_q)
      IDLE: if (start_req) state_d = REQ;
      REQ: begin
        if (mem_data_rdy) begin
          fill    = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     if (data_filled_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q                  <= IDLE;
      valid_q                  <= '0;
      request_inst_memory_addr <= '0;
    end else begin
      state_q <= state_d;
      if (start_req)
        request_inst_memory_addr <= {pc[MEM_ADDRESS_LEN-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      if (fill)
        valid_q[fill_index] <= 1'b1;
    end
  end

  // NOTE: tag/data storage has no reset; valid_q alone decides whether contents are used.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[fill_index] <= instr_from_mem;
      tag_q[fill_index]  <= fill_tag;
    end
  end

endmodule

// File: rtl/pc_icache_unit.sv
// Fetch front end: PC register, next-PC mux and instruction cache.
//   clk                      in   system clock
//   reset                    in   asynchronous active-low reset
//   PCbranch                 in   branch target
//   branch_hit               in   take PCbranch as the next PC
//   wrt_en                   in   pipeline enable (0 = stall)
//   instr_from_mem           in   refill line from memory
//   mem_data_rdy             in   refill line valid
//   data_filled_ack          in   memory ends refill transaction
//   PCnext                   out  registered PC+4 (or branch target) handed to decode
//   instruction              out  fetched instruction, 0 on miss
//   inst_valid               out  instruction is a cache hit
//   request_inst_memory      out  refill request
//   request_inst_memory_addr out  line-aligned refill address
module pc_icache_unit
  import pc_icache_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [VIRT_ADDR_WIDTH-1:0]   PCbranch,
  input  logic                         branch_hit,
  input  logic                         wrt_en,
  input  logic [ICACHE_LINE_WIDTH-1:0] instr_from_mem,
  input  logic                         mem_data_rdy,
  input  logic                         data_filled_ack,
  output logic [VIRT_ADDR_WIDTH-1:0]   PCnext,
  output logic [INST_WIDTH-1:0]        instruction,
  output logic                         inst_valid,
  output logic                         request_inst_memory,
  output logic [MEM_ADDRESS_LEN-1:0]   request_inst_memory_addr
);

  logic [VIRT_ADDR_WIDTH-1:0] pc_q;
  logic [VIRT_ADDR_WIDTH-1:0] next_pc;
  logic                       hit;
  logic                       advance;

  // A taken branch advances even on a miss; the in-flight refill still completes.
  assign next_pc = branch_hit ? PCbranch : pc_q + VIRT_ADDR_WIDTH'(4);
  assign advance = wrt_en && (hit || branch_hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= BOOT_PC;
      PCnext <= '0;
    end else if (advance) begin
      pc_q   <= next_pc;
      PCnext <= next_pc;
    end
  end

  assign inst_valid = hit;

  pc_icache_array u_array (
    .clk                      (clk),
    .reset                    (reset),
    .pc                       (pc_q),
    .wrt_en                   (wrt_en),
    .instr_from_mem           (instr_from_mem),
    .mem_data_rdy             (mem_data_rdy),
    .data_filled_ack          (data_filled_ack),
    .instruction              (instruction),
    .hit                      (hit),
    .request_inst_memory      (request_inst_memory),
    .request_inst_memory_addr (request_inst_memory_addr)
  );

endmodule

// File: tb/tb_pc_icache_unit.sv
// Directed self-checking bench for pc_icache_unit. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_pc_icache_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  PCbranch;
  logic         branch_hit;
  logic         wrt_en;
  logic [127:0] instr_from_mem;
  logic         mem_data_rdy;
  logic         data_filled_ack;
  logic [31:0]  PCnext;
  logic [31:0]  instruction;
  logic         inst_valid;
  logic         request_inst_memory;
  logic [31:0]  request_inst_memory_addr;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [127:0] LINE_A = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [127:0] LINE_B = {32'h88, 32'h77, 32'h66, 32'h55};
  localparam logic [127:0] LINE_C = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
  localparam logic [127:0] JUNK   = {4{32'hDEAD_BEEF}};

  always #5 clk = ~clk;

  pc_icache_unit dut (
    .clk                      (clk),
    .reset                    (reset),
    .PCbranch                 (PCbranch),
    .branch_hit               (branch_hit),
    .wrt_en                   (wrt_en),
    .instr_from_mem           (instr_from_mem),
    .mem_data_rdy             (mem_data_rdy),
    .data_filled_ack          (data_filled_ack),
    .PCnext                   (PCnext),
    .instruction              (instruction),
    .inst_valid               (inst_valid),
    .request_inst_memory      (request_inst_memory),
    .request_inst_memory_addr (request_inst_memory_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Snapshot of the decode-facing outputs against hand-computed values.
  task automatic expect_out(input string tag, input logic [31:0] pcn, input logic [31:0] ins,
                            input logic vld, input logic req);
    check({tag, ".PCnext"}, PCnext, pcn);
    check({tag, ".instruction"}, instruction, ins);
    check({tag, ".inst_valid"}, 32'(inst_valid), 32'(vld));
    check({tag, ".req"}, 32'(request_inst_memory), 32'(req));
  endtask

  initial begin
    reset           = 1'b0;
    PCbranch        = '0;
    branch_hit      = 1'b0;
    wrt_en          = 1'b0;
    instr_from_mem  = '0;
    mem_data_rdy    = 1'b0;
    data_filled_ack = 1'b0;

    // Reset state
    tick();
    tick();
    expect_out("rst", 32'h0, 32'h0, 1'b0, 1'b0);
    check("rst.addr", request_inst_memory_addr, 32'h0);

    // Release; cold miss at BOOT_PC
    reset  = 1'b1;
    wrt_en = 1'b1;
    tick();
    expect_out("cold_req", 32'h0, 32'h0, 1'b0, 1'b1);
    check("cold_req.addr", request_inst_memory_addr, 32'h1000);

    // Ack outside ACK is ignored: request stays up
    data_filled_ack = 1'b1;
    tick();
    data_filled_ack = 1'b0;
    expect_out("req_hold", 32'h0, 32'h0, 1'b0, 1'b1);
    check("req_hold.addr", request_inst_memory_addr, 32'h1000);

    // Refill line 0
    mem_data_rdy   = 1'b1;
    instr_from_mem = LINE_A;
    tick();
    mem_data_rdy   = 1'b0;
    instr_from_mem = '0;
    expect_out("fill_a", 32'h0, 32'h11, 1'b1, 1'b0);

    data_filled_ack = 1'b1;
    tick();
    data_filled_ack = 1'b0;
    expect_out("seq_1004", 32'h1004, 32'h22, 1'b1, 1'b0);

    // Branch on hit: 0x1004 -> 0x1008
    branch_hit = 1'b1;
    PCbranch   = 32'h1008;
    tick();
    branch_hit = 1'b0;
    expect_out("br_1008", 32'h1008, 32'h33, 1'b1, 1'b0);

    // Stall 3 cycles; stray mem_data_rdy in IDLE must not write the line
    wrt_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_data_rdy   = (i == 1);
      instr_from_mem = (i == 1) ? JUNK : '0;
      tick();
      expect_out($sformatf("stall%0d", i), 32'h1008, 32'h33, 1'b1, 1'b0);
    end
    mem_data_rdy   = 1'b0;
    instr_from_mem = '0;
    wrt_en         = 1'b1;

    tick();
    expect_out("seq_100c", 32'h100C, 32'h44, 1'b1, 1'b0);
    tick();
    expect_out("miss_1010", 32'h1010, 32'h0, 1'b0, 1'b0);
    tick();
    expect_out("req_1010", 32'h1010, 32'h0, 1'b0, 1'b1);
    check("req_1010.addr", request_inst_memory_addr, 32'h1010);

    // rdy and ack together in REQ: fill, but the ack is not consumed
    mem_data_rdy    = 1'b1;
    data_filled_ack = 1'b1;
    instr_from_mem  = LINE_B;
    tick();
    mem_data_rdy    = 1'b0;
    data_filled_ack = 1'b0;
    instr_from_mem  = '0;
    expect_out("fill_b", 32'h1010, 32'h55, 1'b1, 1'b0);

    // Branch to 0x1040 (index 0, other tag) while still in ACK
    branch_hit = 1'b1;
    PCbranch   = 32'h1040;
    tick();
    branch_hit = 1'b0;
    expect_out("br_1040", 32'h1040, 32'h0, 1'b0, 1'b0);
    tick();
    expect_out("ack_wait", 32'h1040, 32'h0, 1'b0, 1'b0);
    data_filled_ack = 1'b1;
    tick();
    data_filled_ack = 1'b0;
    expect_out("ack_done", 32'h1040, 32'h0, 1'b0, 1'b0);
    tick();
    expect_out("req_1040", 32'h1040, 32'h0, 1'b0, 1'b1);
    check("req_1040.addr", request_inst_memory_addr, 32'h1040);

    // Conflict fill evicts line 0
    mem_data_rdy   = 1'b1;
    instr_from_mem = LINE_C;
    tick();
    mem_data_rdy   = 1'b0;
    instr_from_mem = '0;
    expect_out("fill_c", 32'h1040, 32'hA0, 1'b1, 1'b0);
    data_filled_ack = 1'b1;
    tick();
    data_filled_ack = 1'b0;
    expect_out("seq_1044", 32'h1044, 32'hB1, 1'b1, 1'b0);

    branch_hit = 1'b1;
    PCbranch   = 32'h1000;
    tick();
    branch_hit = 1'b0;
    expect_out("evicted", 32'h1000, 32'h0, 1'b0, 1'b0);
    tick();
    expect_out("rereq_1000", 32'h1000, 32'h0, 1'b0, 1'b1);
    check("rereq_1000.addr", request_inst_memory_addr, 32'h1000);

    // Asynchronous reset in REQ: request drops without a clock edge
    #2 reset = 1'b0;
    #1;
    check("async.req", 32'(request_inst_memory), 32'h0);
    check("async.addr", request_inst_memory_addr, 32'h0);
    check("async.PCnext", PCnext, 32'h0);

    // Data offered during reset must not be written
    mem_data_rdy   = 1'b1;
    instr_from_mem = LINE_A;
    tick();
    tick();
    mem_data_rdy   = 1'b0;
    instr_from_mem = '0;
    wrt_en         = 1'b0;
    reset          = 1'b1;
    #1;
    expect_out("post_rst", 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    wrt_en = 1'b1;
    tick();
    expect_out("post_rst_req", 32'h0, 32'h0, 1'b0, 1'b1);
    check("post_rst_req.addr", request_inst_memory_addr, 32'h1000);

    mem_data_rdy   = 1'b1;
    instr_from_mem = LINE_A;
    tick();
    mem_data_rdy   = 1'b0;
    instr_from_mem = '0;
    expect_out("post_rst_fill", 32'h0, 32'h11, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
